// File: rtl/mux_reg_n.sv
// rtl/mux_reg_n.sv - registered N-way word multiplexer with valid/ready handshake
//
// Selects one WIDTH-bit lane out of N input lanes and registers it for a
// single-lane downstream consumer. The lane comes either from the external
// select (direct mode) or from an internal round-robin scan pointer (scan mode).
//
// Parameters:
//   WIDTH  bits per lane
//   N      number of input lanes (2..16, need not be a power of two)
//   SELW   select width, 2**SELW >= N
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    N lanes, lane k at [k*WIDTH +: WIDTH]
//   in_valid   in_data/sel/mode valid this cycle
//   in_ready   block can accept this cycle
//   mode       0 = direct (sel), 1 = scan (internal pointer)
//   sel        lane index in direct mode
//   out_data   registered selected lane
//   out_sel    lane index that produced out_data
//   out_err    word came from a direct-mode sel >= N
//   out_valid  output register holds an unconsumed word
//   out_ready  downstream accepts out_data this cycle

module mux_reg_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);

  // Lane count and last lane index expressed in select-sized arithmetic.
  // N_EXT carries one extra bit so N == 2**SELW still compares correctly.
  localparam logic [SELW:0]   N_EXT = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST  = SELW'(N - 1);

  logic [SELW-1:0]  scan_ptr;
  logic [SELW-1:0]  idx;
  logic             in_range;
  logic [WIDTH-1:0] lane_data;
  logic             accept;

  logic [WIDTH-1:0] data_nxt;
  logic [SELW-1:0]  sel_nxt;
  logic             err_nxt;
  logic             valid_nxt;
  logic [SELW-1:0]  ptr_nxt;

  // Ready depends only on the output register, never on in_valid, so the
  // upstream source can use it without a combinational loop.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign idx      = mode ? scan_ptr : sel;
  assign in_range = ({1'b0, idx} < N_EXT);

  // Compare-and-pick rather than indexing, so an out-of-range select reads
  // as zero instead of touching bits past the top lane.
  always_comb begin
    lane_data = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == SELW'(k)) begin
        lane_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state values for the output register and scan pointer.
  always_comb begin
    data_nxt  = out_data;
    sel_nxt   = out_sel;
    err_nxt   = out_err;
    valid_nxt = out_valid;
    ptr_nxt   = scan_ptr;
    if (accept) begin
      data_nxt  = lane_data;
      sel_nxt   = idx;
      // Scan pointer never leaves 0..N-1, so only direct mode can err.
      err_nxt   = !in_range;
      valid_nxt = 1'b1;
      if (mode) begin
        ptr_nxt = (scan_ptr == LAST) ? '0 : scan_ptr + 1'b1;
      end
    end else if (out_ready) begin
      // Word consumed with nothing new: payload holds its last value.
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      scan_ptr  <= '0;
    end else begin
      out_data  <= data_nxt;
      out_sel   <= sel_nxt;
      out_err   <= err_nxt;
      out_valid <= valid_nxt;
      scan_ptr  <= ptr_nxt;
    end
  end

endmodule
